axis_multipass_frame_sequencer: RTL and testbench

//  Feeds Image_HazeRemoval. Streams NUM_PASSES copies of one IMG_W x IMG_H frame

---
 rtl/axis_multipass_frame_sequencer.sv | 141 ++++++++++++++
 tb/tb_axis_multipass_frame_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/axis_multipass_frame_sequencer.sv
// rtl/axis_multipass_frame_sequencer.sv - replays one upstream frame NUM_PASSES times into a stream core
// TLAST is regenerated from an internal beat counter; a 2-entry skid buffer isolates core backpressure.
module axis_multipass_frame_sequencer #(
   parameter int DATA_W     = 32,
   parameter int IMG_W      = 512,
   parameter int IMG_H      = 512,
   parameter int NUM_PASSES = 2,
   parameter int GAP_CYCLES = 1,
   parameter int CNT_W      = 20
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              enable,
   input  logic [DATA_W-1:0] S_AXIS_TDATA,
   input  logic              S_AXIS_TVALID,
   input  logic              S_AXIS_TLAST,
   output logic              S_AXIS_TREADY,
   output logic [DATA_W-1:0] M_AXIS_TDATA,
   output logic              M_AXIS_TVALID,
   output logic              M_AXIS_TLAST,
   input  logic              M_AXIS_TREADY,
   output logic [3:0]        pass_id,
   output logic              seq_done,
   output logic              tlast_err
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IMG_W * IMG_H - 1);
   localparam logic [3:0]       LAST_PASS = 4'(NUM_PASSES - 1);
   localparam logic [7:0]       GAP_LAST  = 8'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP, S_DRAIN} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  beat_cnt;
   logic [7:0]        gap_cnt;
   logic [3:0]        pass_r;
   logic              err_r;
   logic              s_ready_r;
   logic [DATA_W-1:0] buf_data [2];
   logic [1:0]        buf_last;
   logic              wr_ptr, rd_ptr;
   logic [1:0]        count, count_nxt;
   logic              push, pop, last_beat, start, pass_adv;

   assign push      = S_AXIS_TVALID & s_ready_r;
   assign pop       = (count != 2'd0) & M_AXIS_TREADY;
   assign last_beat = (beat_cnt == LAST_BEAT);
   assign count_nxt = count + {1'b0, push} - {1'b0, pop};

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      pass_adv  = 1'b0;
      seq_done  = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable) begin
               state_nxt = S_STREAM;
               start     = 1'b1;
            end
         end
         S_STREAM: begin
            if (push && last_beat) begin
               if (pass_r == LAST_PASS)  state_nxt = S_DRAIN;
               else if (GAP_CYCLES == 0) pass_adv  = 1'b1;
               else                      state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = S_STREAM;
               pass_adv  = 1'b1;
            end
         end
         S_DRAIN: begin
            if (count == 2'd0) begin
               seq_done  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Ready looks at next state and next occupancy so a registered ready can never overfill the buffer.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         beat_cnt  <= '0;
         gap_cnt   <= 8'd0;
         pass_r    <= 4'd0;
         err_r     <= 1'b0;
         s_ready_r <= 1'b0;
      end else begin
         s_ready_r <= (state_nxt == S_STREAM) & enable & (count_nxt < 2'd2);
         gap_cnt   <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
         if (start) begin
            beat_cnt <= '0;
            pass_r   <= 4'd0;
            err_r    <= 1'b0;
         end else begin
            if (push) begin
               beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
               if (S_AXIS_TLAST != last_beat) err_r <= 1'b1;
            end
            if (pass_adv) pass_r <= pass_r + 4'd1;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
         buf_data[0] <= '0;
         buf_data[1] <= '0;
         buf_last    <= 2'b00;
      end else begin
         if (push) begin
            buf_data[wr_ptr] <= S_AXIS_TDATA;
            buf_last[wr_ptr] <= last_beat;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count_nxt;
      end
   end

   assign M_AXIS_TVALID = (count != 2'd0);
   assign M_AXIS_TDATA  = M_AXIS_TVALID ? buf_data[rd_ptr] : '0;
   assign M_AXIS_TLAST  = M_AXIS_TVALID & buf_last[rd_ptr];
   assign S_AXIS_TREADY = s_ready_r;
   assign pass_id       = pass_r;
   assign tlast_err     = err_r;

endmodule

// File: tb/tb_axis_multipass_frame_sequencer.sv
// tb/tb_axis_multipass_frame_sequencer.sv - directed self-checking bench for the multi-pass frame sequencer
`timescale 1ns/1ps
module tb_axis_multipass_frame_sequencer;

   logic        ACLK = 1'b0;
   logic        arstn = 1'b0;
   logic        sel = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] s_tdata = 32'd0;
   logic        s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0;

   logic        s_tready0, m_tvalid0, m_tlast0, seq_done0, tlast_err0;
   logic        s_tready1, m_tvalid1, m_tlast1, seq_done1, tlast_err1;
   logic [31:0] m_tdata0, m_tdata1;
   logic [3:0]  pass_id0, pass_id1;

   logic        s_tready, m_tvalid, m_tlast, seq_done, tlast_err;
   logic [31:0] m_tdata;
   logic [3:0]  pass_id;

   int tests = 0;
   int fails = 0;
   int npass = 2;

   always #5 ACLK = ~ACLK;

   axis_multipass_frame_sequencer #(.DATA_W(32), .IMG_W(4), .IMG_H(2), .NUM_PASSES(2),
                                    .GAP_CYCLES(1), .CNT_W(20)) u_dut (
      .ACLK(ACLK), .ARESETn(arstn & ~sel), .enable(enable),
      .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
      .S_AXIS_TREADY(s_tready0), .M_AXIS_TDATA(m_tdata0), .M_AXIS_TVALID(m_tvalid0),
      .M_AXIS_TLAST(m_tlast0), .M_AXIS_TREADY(m_tready), .pass_id(pass_id0),
      .seq_done(seq_done0), .tlast_err(tlast_err0));

   axis_multipass_frame_sequencer #(.DATA_W(32), .IMG_W(4), .IMG_H(2), .NUM_PASSES(1),
                                    .GAP_CYCLES(0), .CNT_W(20)) u_dut_single (
      .ACLK(ACLK), .ARESETn(arstn & sel), .enable(enable),
      .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
      .S_AXIS_TREADY(s_tready1), .M_AXIS_TDATA(m_tdata1), .M_AXIS_TVALID(m_tvalid1),
      .M_AXIS_TLAST(m_tlast1), .M_AXIS_TREADY(m_tready), .pass_id(pass_id1),
      .seq_done(seq_done1), .tlast_err(tlast_err1));

   assign s_tready  = sel ? s_tready1  : s_tready0;
   assign m_tvalid  = sel ? m_tvalid1  : m_tvalid0;
   assign m_tlast   = sel ? m_tlast1   : m_tlast0;
   assign m_tdata   = sel ? m_tdata1   : m_tdata0;
   assign pass_id   = sel ? pass_id1   : pass_id0;
   assign seq_done  = sel ? seq_done1  : seq_done0;
   assign tlast_err = sel ? tlast_err1 : tlast_err0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_s_tready"}, s_tready, 0);
      check({tag, "_m_tvalid"}, m_tvalid, 0);
      check({tag, "_m_tdata"},  m_tdata,  0);
      check({tag, "_m_tlast"},  m_tlast,  0);
      check({tag, "_pass_id"},  pass_id,  0);
      check({tag, "_seq_done"}, seq_done, 0);
      check({tag, "_tlast_err"}, tlast_err, 0);
   endtask

   // mode 0: core always ready, 1: ready toggles 1,0,1,0, 2: ready only for the first 4 beats
   task automatic run_seq(input int mode, input bit inject, input bit pause_en, input bit do_rst);
      int src = 0, mc = 0, cyc = 0, done_cnt = 0, post = 0;
      int idle8 = 0, idle_other = 0, trlow8 = 0, pause_left = 0, occ;
      int total = 8 * npass;
      bit sf, mf, hit = 1'b0;
      while (cyc < 300 && post < 3) begin
         enable   = (src < total) && (pause_left == 0);
         s_tvalid = enable;
         s_tdata  = 32'(src % 8 + 1);
         s_tlast  = ((src % 8) == 7) ^ (inject && src == 4);
         m_tready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : (mc < 4);
         occ = src - mc;
         if (s_tready) check("full_rdy", occ < 2, 1);
         if (m_tvalid) begin
            check("m_data", m_tdata, (mc % 8) + 1);
            check("m_last", m_tlast, (mc % 8) == 7);
         end else if (mode == 0 && !pause_en && mc > 0 && mc < total) begin
            if (mc == 8) idle8++;
            else         idle_other++;
         end
         if (!s_tready && src == 8) trlow8++;
         if (seq_done) begin
            check("done_at", mc, total);
            done_cnt++;
         end
         if (done_cnt > 0) post++;
         if (pause_left inside {1, 2}) check("pause_rdy", s_tready, 0);
         sf = s_tvalid & s_tready;
         mf = m_tvalid & m_tready;
         if (sf) begin
            check("pass_id", pass_id, src / 8);
            if (src == 0) check("err_clr", tlast_err, 0);
         end
         @(posedge ACLK);
         #1;
         cyc++;
         if (sf) src++;
         if (mf) mc++;
         if (sf && inject && src == 5) check("err_set", tlast_err, 1);
         if (pause_left > 0) pause_left--;
         else if (pause_en && sf && src == 11) pause_left = 3;
         if (do_rst && src == 6 && (src - mc) == 2) begin
            arstn = 1'b0;
            #1;
            check_outputs_zero("rst_mid");
            hit = 1'b1;
            break;
         end
      end
      enable   = 1'b0;
      s_tvalid = 1'b0;
      if (do_rst) begin
         check("rst_hit", hit, 1);
      end else begin
         check("beats", mc, total);
         check("done_cnt", done_cnt, 1);
         check("end_err", tlast_err, {31'd0, inject});
         check("idle_rdy", s_tready, 0);
         check("idle_vld", m_tvalid, 0);
         if (mode == 0 && npass == 2 && !pause_en) begin
            check("m_gap", idle8, 1);
            check("gap_rdy", trlow8, 1);
         end
         if (mode == 0 && !pause_en) check("bubble", idle_other, 0);
      end
   endtask

   initial begin
      repeat (3) @(posedge ACLK);
      #1;
      check_outputs_zero("reset");
      arstn = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;

      npass = 2;
      run_seq(0, 1'b0, 1'b0, 1'b0);
      run_seq(1, 1'b0, 1'b0, 1'b0);
      run_seq(0, 1'b1, 1'b0, 1'b0);
      run_seq(0, 1'b0, 1'b1, 1'b0);
      run_seq(2, 1'b0, 1'b0, 1'b1);
      repeat (2) @(posedge ACLK);
      #1;
      check_outputs_zero("rst_hold");
      arstn = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      run_seq(0, 1'b0, 1'b0, 1'b0);

      sel   = 1'b1;
      npass = 1;
      repeat (2) @(posedge ACLK);
      #1;
      check_outputs_zero("single_reset");
      run_seq(0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge ACLK);
      #1;
      check("single_idle_rdy", s_tready, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
